// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the handshaked ALU.
//   - Function-code class and op selectors (ALU_FUN[3:2] / ALU_FUN[1:0]).
//   - Handshake FSM state encoding.
//   - Bit positions of the one-hot class flags and a helper that builds them.
package alu_pkg;

    // Class selectors, ALU_FUN[3:2]
    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_CMP   = 2'b10;
    localparam logic [1:0] CLS_SHIFT = 2'b11;

    // Arithmetic ops
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Logic ops
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    // Compare ops (unsigned)
    localparam logic [1:0] OP_EQ    = 2'b00;
    localparam logic [1:0] OP_GT    = 2'b01;
    localparam logic [1:0] OP_LT    = 2'b10;
    localparam logic [1:0] OP_CNONE = 2'b11;

    // Shift ops
    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    // Handshake FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } alu_state_e;

    // ALU_FLAGS bit positions
    localparam int unsigned FLAG_ARITH = 0;
    localparam int unsigned FLAG_LOGIC = 1;
    localparam int unsigned FLAG_CMP   = 2;
    localparam int unsigned FLAG_SHIFT = 3;

    function automatic logic [3:0] class_flag(input logic [1:0] cls);
        logic [3:0] f;
        f = '0;
        unique case (cls)
            CLS_ARITH: f[FLAG_ARITH] = 1'b1;
            CLS_LOGIC: f[FLAG_LOGIC] = 1'b1;
            CLS_CMP:   f[FLAG_CMP]   = 1'b1;
            CLS_SHIFT: f[FLAG_SHIFT] = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu_serial_div.sv
// alu_serial_div: unsigned restoring divider, one quotient bit per cycle.
//   clk, rst_n  clock and asynchronous active-low reset
//   start       load operands; the first iteration is performed on this edge
//   dividend    numerator, sampled with start
//   divisor     denominator, sampled with start (must be non-zero)
//   done        one-cycle pulse, DATA_WIDTH cycles after the start edge
//   quotient    result, valid while done is high (held until the next start)
//   remainder   result, valid while done is high (held until the next start)
module alu_serial_div #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);
    localparam int unsigned W         = DATA_WIDTH;
    localparam int unsigned CNT_WIDTH = $clog2(DATA_WIDTH + 1);

    logic                 busy_q;
    logic                 done_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [W-1:0]         rem_q;
    logic [W-1:0]         quo_q;
    logic [W-1:0]         dvs_q;

    logic [W-1:0] src_rem;
    logic [W-1:0] src_quo;
    logic [W-1:0] src_dvs;
    logic [W:0]   shifted;
    logic [W:0]   trial;
    logic         fits;
    logic [W-1:0] nxt_rem;
    logic [W-1:0] nxt_quo;

    // On start the iteration works straight from the input operands so that
    // W edges (start edge included) produce all W quotient bits.
    assign src_rem = start ? '0 : rem_q;
    assign src_quo = start ? dividend : quo_q;
    assign src_dvs = start ? divisor : dvs_q;

    // Quotient register doubles as the dividend shift register.
    assign shifted = {src_rem, src_quo[W-1]};
    assign trial   = shifted - {1'b0, src_dvs};
    assign fits    = ~trial[W];
    assign nxt_rem = fits ? trial[W-1:0] : shifted[W-1:0];
    assign nxt_quo = {src_quo[W-2:0], fits};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
            cnt_q  <= CNT_WIDTH'(1);
            rem_q  <= nxt_rem;
            quo_q  <= nxt_quo;
            dvs_q  <= divisor;
        end else if (busy_q) begin
            rem_q <= nxt_rem;
            quo_q <= nxt_quo;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered result stage and serial divider.
//   CLK, RST    clock, asynchronous active-low reset
//   IN_VALID    request present          IN_READY   request taken this cycle
//   A, B        operands                 ALU_FUN    {class[1:0], op[1:0]}
//   OUT_VALID   result held              OUT_READY  consumer takes the result
//   ALU_OUT     2*DATA_WIDTH result      CARRY_OUT  ADD carry / SUB borrow
//   ALU_FLAGS   one-hot class of result  ERR_FLAG   divide by zero
//   BUSY        divider iterating
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned SHAMT_WIDTH   = $clog2(DATA_WIDTH),
    parameter int unsigned ALU_FUN_WIDTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [DATA_WIDTH-1:0]    A,
    input  logic [DATA_WIDTH-1:0]    B,
    input  logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [2*DATA_WIDTH-1:0]  ALU_OUT,
    output logic                     CARRY_OUT,
    output logic [3:0]               ALU_FLAGS,
    output logic                     ERR_FLAG,
    output logic                     BUSY
);
    localparam int unsigned W = DATA_WIDTH;
    localparam logic [SHAMT_WIDTH:0] W_AMT = (SHAMT_WIDTH + 1)'(DATA_WIDTH);

    alu_state_e     state_q;
    logic           out_valid_q;
    logic [2*W-1:0] alu_out_q;
    logic           carry_q;
    logic [3:0]     flags_q;
    logic           err_q;

    logic [1:0] cls;
    logic [1:0] op;
    logic       accept;
    logic       is_div;
    logic       div_start;
    logic       load_single;
    logic       div_done;
    logic       div_done_raw;
    logic [W-1:0] div_quo;
    logic [W-1:0] div_rem;

    assign cls = ALU_FUN[3:2];
    assign op  = ALU_FUN[1:0];

    assign IN_READY    = (state_q == ST_IDLE) && (!out_valid_q || OUT_READY);
    assign accept      = IN_VALID && IN_READY;
    assign is_div      = (cls == CLS_ARITH) && (op == OP_DIV);
    // Divide by zero never enters the divider; it completes like a single-cycle op.
    assign div_start   = accept && is_div && (B != '0);
    assign load_single = accept && !div_start;
    assign div_done    = div_done_raw && (state_q == ST_DIV);

    alu_serial_div #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_div (
        .clk      (CLK),
        .rst_n    (RST),
        .start    (div_start),
        .dividend (A),
        .divisor  (B),
        .done     (div_done_raw),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    // Single-cycle datapath
    logic [W:0]             sum;
    logic [W-1:0]           diff;
    logic [2*W-1:0]         prod;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [W-1:0]           sra;
    logic [W-1:0]           rol;
    logic [2*W-1:0]         res_comb;
    logic                   carry_comb;
    logic                   err_comb;

    assign sum   = {1'b0, A} + {1'b0, B};
    assign diff  = A - B;
    assign prod  = {{W{1'b0}}, A} * {{W{1'b0}}, B};
    assign shamt = B[SHAMT_WIDTH-1:0];
    assign sra   = $unsigned($signed(A) >>> shamt);
    // A shift by W yields zero, so shamt==0 rotates to A unchanged.
    assign rol   = (A << shamt) | (A >> (W_AMT - {1'b0, shamt}));

    always_comb begin
        res_comb   = '0;
        carry_comb = 1'b0;
        err_comb   = 1'b0;
        unique case (cls)
            CLS_ARITH: begin
                unique case (op)
                    OP_ADD: begin
                        res_comb[W:0] = sum;
                        carry_comb    = sum[W];
                    end
                    OP_SUB: begin
                        res_comb[W-1:0] = diff;
                        carry_comb      = (A < B);
                    end
                    OP_MUL: res_comb = prod;
                    OP_DIV: begin
                        // Only loaded when B==0; real divides load from u_div.
                        res_comb = {A, {W{1'b1}}};
                        err_comb = 1'b1;
                    end
                endcase
            end
            CLS_LOGIC: begin
                unique case (op)
                    OP_AND:  res_comb[W-1:0] = A & B;
                    OP_OR:   res_comb[W-1:0] = A | B;
                    OP_NAND: res_comb[W-1:0] = ~(A & B);
                    OP_NOR:  res_comb[W-1:0] = ~(A | B);
                endcase
            end
            CLS_CMP: begin
                unique case (op)
                    OP_EQ:    res_comb[1:0] = (A == B) ? 2'd1 : 2'd0;
                    OP_GT:    res_comb[1:0] = (A > B) ? 2'd2 : 2'd0;
                    OP_LT:    res_comb[1:0] = (A < B) ? 2'd3 : 2'd0;
                    OP_CNONE: res_comb[1:0] = 2'd0;
                endcase
            end
            CLS_SHIFT: begin
                unique case (op)
                    OP_SRL: res_comb[W-1:0] = A >> shamt;
                    OP_SLL: res_comb[W-1:0] = A << shamt;
                    OP_SRA: res_comb[W-1:0] = sra;
                    OP_ROL: res_comb[W-1:0] = rol;
                endcase
            end
        endcase
    end

    // Handshake FSM and result registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            carry_q     <= 1'b0;
            flags_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (div_start) state_q <= ST_DIV;
                ST_DIV:  if (div_done)  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            if (div_done) begin
                out_valid_q <= 1'b1;
                alu_out_q   <= {div_rem, div_quo};
                carry_q     <= 1'b0;
                flags_q     <= class_flag(CLS_ARITH);
                err_q       <= 1'b0;
            end else if (load_single) begin
                out_valid_q <= 1'b1;
                alu_out_q   <= res_comb;
                carry_q     <= carry_comb;
                flags_q     <= class_flag(cls);
                err_q       <= err_comb;
            end else if (OUT_READY) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign OUT_VALID = out_valid_q;
    assign ALU_OUT   = alu_out_q;
    assign CARRY_OUT = carry_q;
    assign ALU_FLAGS = flags_q;
    assign ERR_FLAG  = err_q;
    assign BUSY      = (state_q == ST_DIV);

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the fixed 16-bit four-unit ALU.
- Same 4-bit function code: ALU_FUN[3:2] selects the class, ALU_FUN[1:0] selects the op.
- Adds valid/ready flow control on input and output, a registered result stage with backpressure, and a multi-cycle serial divider.
- Sits between the register file/sequencer and the writeback; one operation is in flight at a time.

Parameters:
- DATA_WIDTH, 16, width of operands A and B (W); legal range 4..64.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), number of low bits of B used as the shift amount.
- ALU_FUN_WIDTH, 4, function code width; fixed at 4.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  operation request.
- IN_READY  out  1  block accepts a request this cycle.
- A  in  DATA_WIDTH  operand A.
- B  in  DATA_WIDTH  operand B.
- ALU_FUN  in  4  class[3:2], op[1:0].
- OUT_VALID  out  1  result registers hold a valid result.
- OUT_READY  in  1  consumer takes the result.
- ALU_OUT  out  2*DATA_WIDTH  result, zero-extended unless stated otherwise.
- CARRY_OUT  out  1  carry (ADD) or borrow (SUB); 0 for all other ops.
- ALU_FLAGS  out  4  one-hot class of the held result: bit0 arith, bit1 logic, bit2 cmp, bit3 shift.
- ERR_FLAG  out  1  divide by zero.
- BUSY  out  1  divider iterating.

Behaviour:
- Reset (RST=0, asynchronous):
  - Outputs: OUT_VALID, ALU_OUT, CARRY_OUT, ALU_FLAGS, ERR_FLAG and BUSY all 0.
  - State: FSM returns to IDLE and the divider state is cleared.
  - Reset mid-divide aborts the operation with no result emitted.
  - IN_READY is 1 from the first cycle after RST deasserts.
- FSM states and transitions:
  - IDLE: waiting for, or accepting, requests.
  - DIV: serial divide in progress.
  - Accept condition: IN_VALID && IN_READY.
  - IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY).
  - Because IN_READY depends on OUT_READY, back-to-back throughput is 1 op per cycle.
- Single-cycle ops (all except DIV):
  - Result registered on the accept edge; OUT_VALID=1 the next cycle; latency 1.
  - Output holds stable while OUT_VALID && !OUT_READY.
  - OUT_VALID drops after a handshake with no new accept in the same cycle.
  - Simultaneous output handshake and new accept loads the new result and keeps OUT_VALID=1.
- Class 00, arith:
  - 00 ADD: ALU_OUT = A+B on W+1 bits; CARRY_OUT = bit W.
  - 01 SUB: ALU_OUT[W-1:0] = A-B mod 2^W; CARRY_OUT = (A<B); upper bits 0.
  - 10 MUL: full unsigned 2W-bit product.
  - 11 DIV: see below.
- Class 01, logic on W bits: 00 AND, 01 OR, 10 NAND, 11 NOR.
- Class 10, cmp (unsigned): 00 EQ gives 1 if A==B; 01 GT gives 2 if A>B; 10 LT gives 3 if A<B; otherwise 0. Op 11 always gives 0.
- Class 11, shift on A by s=B[SHAMT_WIDTH-1:0]: 00 logical right, 01 logical left (bits shifted out are lost), 10 arithmetic right, 11 rotate left.
- DIV (unsigned, restoring):
  - On accept: FSM enters DIV, BUSY=1, IN_READY=0.
  - Runs exactly W iterations, then result registered, OUT_VALID=1, back to IDLE.
  - Latency W+1 cycles from accept.
  - Result: ALU_OUT = {remainder[W-1:0], quotient[W-1:0]}.
  - The accept condition already requires the output stage free, so the result never overwrites an unconsumed one.
- Divide by zero (B==0): no iteration; latency 1; quotient all ones; remainder = A; ERR_FLAG=1.
- ERR_FLAG and CARRY_OUT belong to the held result and change only when a new result is loaded.
- IN_VALID and operand changes while IN_READY=0 are ignored.
- Unknown or X on ALU_FUN is not defined; the bench must not drive it.

Decomposition:
- Shared package alu_pkg holds:
  - Class localparams: CLS_ARITH=2'b00, CLS_LOGIC=2'b01, CLS_CMP=2'b10, CLS_SHIFT=2'b11.
  - Op localparams per class, e.g. OP_ADD, OP_DIV, OP_SRA.
  - FSM state encoding: ST_IDLE, ST_DIV.
  - Flag bit index constants.
- One natural sub-module: alu_serial_div.
  - Parametrised by DATA_WIDTH.
  - Ports: start, dividend, divisor, done, quotient, remainder.
  - Owns its own iteration counter.
- The top holds the handshake FSM, the combinational single-cycle datapath and the output registers.

Test Plan:
- Reset then ADD: A=16'hFFFF, B=16'h0001, ALU_FUN=4'b0000, OUT_READY=1 -> next cycle OUT_VALID=1, ALU_OUT=32'h0001_0000, CARRY_OUT=1, ALU_FLAGS=4'b0001.
- Backpressure: MUL A=300, B=200 with OUT_READY=0 for 5 cycles -> ALU_OUT=60000 held stable, IN_READY=0 throughout; at OUT_READY=1 a queued SUB A=5, B=7 is accepted the same cycle -> next ALU_OUT[15:0]=16'hFFFE, CARRY_OUT=1.
- DIV: A=100, B=7 -> BUSY=1 for 16 cycles, OUT_VALID at cycle 17 after accept, ALU_OUT={16'd2, 16'd14}, ERR_FLAG=0.
- Divide by zero: A=16'h1234, B=0, DIV -> 1-cycle latency, ALU_OUT={16'h1234, 16'hFFFF}, ERR_FLAG=1.
- Stream of 8 back-to-back ops (AND, OR, NAND, NOR, EQ, GT, LT, SRA) with OUT_READY=1 -> one result per cycle, in order. SRA of A=16'h8000 by B=3 gives 16'hF000. GT with A=9, B=4 gives 2.
- RST asserted during DIV iteration 8 -> all outputs 0 immediately, no result after release, next ADD completes normally with 1-cycle latency.
